// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the VGA pixel frame buffer.
// Holds the controller state encoding and the stripe test-pattern generator.
// No ports; imported by vga_fb_ram and vga_pixel_frame_buffer.
package vga_fb_pkg;

    // Widest pixel word the pattern helper can build; callers slice down to PW.
    localparam int MAX_PW = 64;

    typedef enum logic {
        FILL = 1'b0,
        IDLE = 1'b1
    } fb_state_t;

    // Pattern word for a given address.
    // Every bit of channel c copies address bit (stripe_bit + c).
    function automatic logic [MAX_PW-1:0] stripe_pixel(
        input logic [31:0] addr,
        input int          stripe_bit,
        input int          channels,
        input int          ch_bits
    );
        logic [MAX_PW-1:0] w;
        w = '0;
        for (int c = 0; c < channels; c++) begin
            for (int b = 0; b < ch_bits; b++) begin
                w[c*ch_bits + b] = addr[stripe_bit + c];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple-dual-port inferred pixel RAM with per-channel write enables.
// Ports: clk/reset, write (we, waddr, wdata, be), registered read (re, raddr, rdata).
// Read is read-first with 1-cycle latency; rdata holds when re is low; reset clears rdata only.
module vga_fb_ram
    import vga_fb_pkg::*;
#(
    parameter int CH_BITS  = 1,
    parameter int CHANNELS = 3,
    parameter int ADDR_W   = 14,
    parameter int PW       = CHANNELS * CH_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [PW-1:0]       wdata,
    input  logic [CHANNELS-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [PW-1:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [PW-1:0] mem [DEPTH];

    // Storage has no reset so it maps onto block RAM; contents survive RESET.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (be[c]) begin
                    mem[waddr][c*CH_BITS +: CH_BITS] <= wdata[c*CH_BITS +: CH_BITS];
                end
            end
        end
    end

    // Non-blocking read of mem gives the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_pixel_frame_buffer.sv
// Multi-channel VGA pixel store with stripe test-pattern fill engine.
// Ports: CLK/RESET; read port RD_EN/RD_ADDR -> RD_DATA/RD_VALID (1-cycle latency);
// host write port WR_VALID/WR_READY/WR_ADDR/WR_DATA/WR_MASK; FILL_REQ restarts fill, BUSY flags it.
module vga_pixel_frame_buffer
    import vga_fb_pkg::*;
#(
    parameter int CH_BITS    = 1,
    parameter int CHANNELS   = 3,
    parameter int ADDR_W     = 14,
    parameter int STRIPE_BIT = 8,
    parameter int PW         = CHANNELS * CH_BITS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RD_EN,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    output logic [PW-1:0]       RD_DATA,
    output logic                RD_VALID,
    input  logic                WR_VALID,
    output logic                WR_READY,
    input  logic [ADDR_W-1:0]   WR_ADDR,
    input  logic [PW-1:0]       WR_DATA,
    input  logic [CHANNELS-1:0] WR_MASK,
    input  logic                FILL_REQ,
    output logic                BUSY
);

    fb_state_t           state;
    fb_state_t           state_nxt;
    logic [ADDR_W-1:0]   fill_cnt;
    logic                fill_we;
    logic [MAX_PW-1:0]   pat_full;
    logic [PW-1:0]       pat_word;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [PW-1:0]       ram_wdata;
    logic [CHANNELS-1:0] ram_be;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (fill_cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
            IDLE: if (FILL_REQ)                   state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY     = (state == FILL);
        WR_READY = (state == IDLE) && !RESET;
        // No fill write while RESET is held; the first one lands on the first cycle after release.
        fill_we  = (state == FILL) && !RESET;
    end

    // Fill counter: runs only in FILL and wraps back to 0 on the last write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_cnt <= '0;
        end else if (state == FILL) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_comb begin
        pat_full = stripe_pixel(32'(fill_cnt), STRIPE_BIT, CHANNELS, CH_BITS);
        pat_word = pat_full[PW-1:0];
    end

    // Write-port mux: the fill engine owns the port in FILL and ignores WR_MASK.
    always_comb begin
        if (state == FILL) begin
            ram_we    = fill_we;
            ram_waddr = fill_cnt;
            ram_wdata = pat_word;
            ram_be    = {CHANNELS{1'b1}};
        end else begin
            ram_we    = WR_VALID && WR_READY;
            ram_waddr = WR_ADDR;
            ram_wdata = WR_DATA;
            ram_be    = WR_MASK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= RD_EN;
        end
    end

    vga_fb_ram #(
        .CH_BITS  (CH_BITS),
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W),
        .PW       (PW)
    ) u_ram (
        .clk   (CLK),
        .reset (RESET),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .re    (RD_EN),
        .raddr (RD_ADDR),
        .rdata (RD_DATA)
    );

endmodule

// File: tb/tb_vga_pixel_frame_buffer.sv
// Directed bench for vga_pixel_frame_buffer at ADDR_W=10, STRIPE_BIT=8, 1-bit RGB.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Expected values are hand-derived from the stripe rule: channel c = addr[8+c].
module tb_vga_pixel_frame_buffer;

    localparam int CH_BITS    = 1;
    localparam int CHANNELS   = 3;
    localparam int ADDR_W     = 10;
    localparam int STRIPE_BIT = 8;
    localparam int PW         = CHANNELS * CH_BITS;

    logic                CLK = 1'b0;
    logic                RESET;
    logic                RD_EN;
    logic [ADDR_W-1:0]   RD_ADDR;
    logic [PW-1:0]       RD_DATA;
    logic                RD_VALID;
    logic                WR_VALID;
    logic                WR_READY;
    logic [ADDR_W-1:0]   WR_ADDR;
    logic [PW-1:0]       WR_DATA;
    logic [CHANNELS-1:0] WR_MASK;
    logic                FILL_REQ;
    logic                BUSY;

    int checks = 0;
    int passes = 0;

    vga_pixel_frame_buffer #(
        .CH_BITS    (CH_BITS),
        .CHANNELS   (CHANNELS),
        .ADDR_W     (ADDR_W),
        .STRIPE_BIT (STRIPE_BIT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RD_EN    (RD_EN),
        .RD_ADDR  (RD_ADDR),
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .WR_VALID (WR_VALID),
        .WR_READY (WR_READY),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .WR_MASK  (WR_MASK),
        .FILL_REQ (FILL_REQ),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [PW-1:0] exp, input string tag);
        RD_EN   = 1'b1;
        RD_ADDR = a;
        step();
        RD_EN   = 1'b0;
        chk({tag, "_vld"}, 32'(RD_VALID), 32'd1);
        chk(tag, 32'(RD_DATA), 32'(exp));
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [PW-1:0] d,
                      input logic [CHANNELS-1:0] m, input string tag);
        WR_VALID = 1'b1;
        WR_ADDR  = a;
        WR_DATA  = d;
        WR_MASK  = m;
        chk({tag, "_rdy"}, 32'(WR_READY), 32'd1);
        step();
        WR_VALID = 1'b0;
    endtask

    // Steps until BUSY drops; returns cycles taken, capped so a stuck DUT still finishes.
    task automatic wait_fill(output int cnt);
        cnt = 0;
        while (BUSY && cnt < 5000) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        int           cnt;
        int           rdy_seen;
        logic [PW-1:0] mid_data;

        RESET = 1'b1; RD_EN = 1'b0; RD_ADDR = '0; WR_VALID = 1'b0;
        WR_ADDR = '0; WR_DATA = '0; WR_MASK = '0; FILL_REQ = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
        chk("rst_rd_data",  32'(RD_DATA),  32'd0);
        chk("rst_wr_ready", 32'(WR_READY), 32'd0);
        chk("rst_busy",     32'(BUSY),     32'd1);

        // Initial fill: 1024 cycles
        RESET = 1'b0;
        wait_fill(cnt);
        chk("fill_len", 32'(cnt), 32'd1024);
        chk("idle_wr_ready", 32'(WR_READY), 32'd1);
        rd(10'h000, 3'b000, "pat_000");
        rd(10'h100, 3'b001, "pat_100");
        rd(10'h300, 3'b011, "pat_300");
        rd(10'h3FF, 3'b011, "pat_3ff");
        step();
        chk("rd_idle_vld", 32'(RD_VALID), 32'd0);
        chk("rd_hold",     32'(RD_DATA),  32'(3'b011));

        // Masked write: only G lands
        wr(10'h055, 3'b111, 3'b010, "mask_wr");
        rd(10'h055, 3'b010, "mask_rd");

        // Zero mask completes but changes nothing
        wr(10'h055, 3'b101, 3'b000, "nomask_wr");
        rd(10'h055, 3'b010, "nomask_rd");

        // Same-cycle write/read: read-first, then new value
        WR_VALID = 1'b1; WR_ADDR = 10'h200; WR_DATA = 3'b101; WR_MASK = 3'b111;
        RD_EN = 1'b1; RD_ADDR = 10'h200;
        step();
        WR_VALID = 1'b0;
        chk("coll_old", 32'(RD_DATA), 32'(3'b010));
        step();
        RD_EN = 1'b0;
        chk("coll_new", 32'(RD_DATA), 32'(3'b101));
        step();

        // Burst of 8 back-to-back reads across the 0x100 stripe edge
        chk("burst_pre_vld", 32'(RD_VALID), 32'd0);
        for (int i = 0; i < 8; i++) begin
            RD_EN   = 1'b1;
            RD_ADDR = 10'(10'h0FC + i);
            step();
            chk("burst_vld",  32'(RD_VALID), 32'd1);
            chk("burst_data", 32'(RD_DATA), (i >= 4) ? 32'd1 : 32'd0);
        end
        RD_EN = 1'b0;
        step();
        chk("burst_post_vld", 32'(RD_VALID), 32'd0);

        // Host writes, then FILL_REQ wipes them
        wr(10'h000, 3'b111, 3'b111, "pre_wr0");
        wr(10'h300, 3'b100, 3'b111, "pre_wr1");
        wr(10'h3FF, 3'b100, 3'b111, "pre_wr2");
        rd(10'h000, 3'b111, "pre_rd0");
        FILL_REQ = 1'b1;
        step();
        FILL_REQ = 1'b0;
        WR_VALID = 1'b1; WR_ADDR = 10'h101; WR_DATA = 3'b110; WR_MASK = 3'b111;
        rdy_seen = 0;
        cnt = 0;
        while (BUSY && cnt < 5000) begin
            if (WR_READY) rdy_seen++;
            step();
            cnt++;
        end
        WR_VALID = 1'b0;
        chk("refill_len", 32'(cnt), 32'd1024);
        chk("refill_rdy_low", 32'(rdy_seen), 32'd0);
        rd(10'h000, 3'b000, "refill_000");
        rd(10'h300, 3'b011, "refill_300");
        rd(10'h055, 3'b000, "refill_055");
        rd(10'h200, 3'b010, "refill_200");
        rd(10'h101, 3'b001, "refill_101");
        rd(10'h3FF, 3'b011, "refill_3ff");

        // Reset 300 cycles into a fill; 0x3FF host value must survive until the rerun reaches it
        wr(10'h3FF, 3'b100, 3'b111, "mid_wr");
        FILL_REQ = 1'b1;
        step();
        FILL_REQ = 1'b0;
        repeat (300) step();
        RESET = 1'b1;
        RD_EN = 1'b1; RD_ADDR = 10'h000;
        step();
        step();
        chk("mid_rst_vld",  32'(RD_VALID), 32'd0);
        chk("mid_rst_busy", 32'(BUSY),     32'd1);
        chk("mid_rst_rdy",  32'(WR_READY), 32'd0);
        RESET = 1'b0;
        RD_EN = 1'b0;
        mid_data = '0;
        cnt = 0;
        while (BUSY && cnt < 5000) begin
            RD_EN   = (cnt == 10);
            RD_ADDR = 10'h3FF;
            step();
            cnt++;
            if (cnt == 11) mid_data = RD_DATA;
        end
        RD_EN = 1'b0;
        chk("rerun_len",     32'(cnt),      32'd1024);
        chk("rerun_mid_3ff", 32'(mid_data), 32'(3'b100));
        rd(10'h3FF, 3'b011, "rerun_3ff");
        rd(10'h100, 3'b001, "rerun_100");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
